// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// fifo_wr_arbiter : round-robin burst arbiter sharing one FIFO write port
// Revision        : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4,
    localparam int ID_W      = $clog2(NUM_REQ),
    localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic                          fifo_wr_en,
    input  logic                          fifo_full,
    input  logic                          fifo_prog_full,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ID_W-1:0]         r_grant_id;
    logic [ID_W-1:0]         r_last_grant;
    logic [ID_W-1:0]         w_grant_nxt;
    logic [ID_W-1:0]         w_last_nxt;
    logic [ID_W-1:0]         w_sel;
    logic [CNT_W-1:0]        r_beat_cnt;
    logic [CNT_W-1:0]        w_beat_nxt;
    logic                    w_found;
    logic                    w_gnt_valid;
    logic                    w_xfer;
    logic [DATA_WIDTH-1:0]   w_words [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_words[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // First valid requester after last_grant, wrapping modulo NUM_REQ
    always_comb begin : p_rr
        int idx;
        idx     = 0;
        w_sel   = '0;
        w_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(r_last_grant) + k) % NUM_REQ;
            if (!w_found && req_valid[idx]) begin
                w_sel   = ID_W'(idx);
                w_found = 1'b1;
            end
        end
    end

    assign w_gnt_valid = req_valid[r_grant_id];

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant_id;
        w_last_nxt   = r_last_grant;
        w_beat_nxt   = r_beat_cnt;
        busy         = 1'b0;
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = w_words[r_grant_id];
        w_xfer       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found && !fifo_prog_full) begin
                    w_state_nxt = S_BURST;
                    w_grant_nxt = w_sel;
                    w_last_nxt  = w_sel;
                    w_beat_nxt  = '0;
                end
            end
            S_BURST: begin
                busy                  = 1'b1;
                req_ready[r_grant_id] = ~fifo_full;
                w_xfer                = w_gnt_valid & ~fifo_full;
                fifo_wr_en            = w_xfer;
                if (w_xfer) begin
                    w_beat_nxt = r_beat_cnt + CNT_W'(1);
                    if (r_beat_cnt == CNT_W'(MAX_BURST - 1)) begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (!fifo_full) begin
                    // Granted requester went idle; a full FIFO only stalls
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_grant_id   <= '0;
            r_last_grant <= ID_W'(NUM_REQ - 1);
            r_beat_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant_id   <= w_grant_nxt;
            r_last_grant <= w_last_nxt;
            r_beat_cnt   <= w_beat_nxt;
        end
    end

    assign grant_id = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_fifo_wr_arbiter : directed vector bench for fifo_wr_arbiter
// Revision           : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_BURST  = 4;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]         fifo_wr_data;
    logic                          fifo_wr_en;
    logic                          fifo_full;
    logic                          fifo_prog_full;
    logic [1:0]                    grant_id;
    logic                          busy;

    int n_cmp = 0;
    int n_err = 0;

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_WIDTH(DATA_WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .fifo_wr_data  (fifo_wr_data),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_full     (fifo_full),
        .fifo_prog_full(fifo_prog_full),
        .grant_id      (grant_id),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Producer model: requester i offers base[i] + number of words it has sent
    logic [7:0] c_base [NUM_REQ] = '{8'h10, 8'h50, 8'h90, 8'hD0};
    logic [7:0] pcnt [NUM_REQ];
    logic       pclr;

    always @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pclr)
                pcnt[i] <= 8'h00;
            else if (req_valid[i] && req_ready[i])
                pcnt[i] <= pcnt[i] + 8'h01;
        end
    end

    always_comb begin
        req_data = '0;
        for (int i = 0; i < NUM_REQ; i++)
            req_data[i*DATA_WIDTH +: DATA_WIDTH] = c_base[i] + pcnt[i];
    end

    typedef struct {
        bit         rst;
        logic [3:0] valid;
        bit         full;
        bit         pfull;
        bit         busy;
        bit         wr_en;
        logic [1:0] gid;
        logic [3:0] ready;
        logic [7:0] data;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input bit r, input logic [3:0] v, input bit f, input bit pf,
                       input bit b, input bit w, input logic [1:0] g,
                       input logic [3:0] rd, input logic [7:0] d);
        vec_t e;
        e.rst = r; e.valid = v; e.full = f; e.pfull = pf;
        e.busy = b; e.wr_en = w; e.gid = g; e.ready = rd; e.data = d;
        vq.push_back(e);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        pclr           = 1'b1;
        req_valid      = '0;
        fifo_full      = 1'b0;
        fifo_prog_full = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pclr  = 1'b0;
    endtask

    // Drive at the negedge, sample 1 time unit before the next rising edge
    task automatic apply(input logic [3:0] v, input bit f, input bit pf);
        req_valid      = v;
        fifo_full      = f;
        fifo_prog_full = pf;
        #4;
        chk("inv_wr_en_while_full", {31'd0, fifo_wr_en & fifo_full}, 32'd0);
        chk("inv_ready_onehot0", {31'd0, $countones(req_ready) > 1}, 32'd0);
        if (fifo_wr_en)
            chk("inv_wr_en_ready_busy", {31'd0, ($countones(req_ready) == 1) && busy}, 32'd1);
    endtask

    initial begin
        int ecnt [NUM_REQ];
        int g;

        rst_n          = 1'b0;
        pclr           = 1'b1;
        req_valid      = '0;
        fifo_full      = 1'b0;
        fifo_prog_full = 1'b0;
        #7;
        chk("reset_busy",  {31'd0, busy}, 32'd0);
        chk("reset_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        chk("reset_ready", {28'd0, req_ready}, 32'd0);
        chk("reset_gid",   {30'd0, grant_id}, 32'd0);
        @(negedge clk);

        // Single requester: 4-word burst, idle gap, 2 words, valid drops
        add(1, 4'b0001, 0, 0,  0, 0, 2'd0, 4'b0000, 8'h00);
        add(0, 4'b0001, 0, 0,  1, 1, 2'd0, 4'b0001, 8'h10);
        add(0, 4'b0001, 0, 0,  1, 1, 2'd0, 4'b0001, 8'h11);
        add(0, 4'b0001, 0, 0,  1, 1, 2'd0, 4'b0001, 8'h12);
        add(0, 4'b0001, 0, 0,  1, 1, 2'd0, 4'b0001, 8'h13);
        add(0, 4'b0001, 0, 0,  0, 0, 2'd0, 4'b0000, 8'h00);
        add(0, 4'b0001, 0, 0,  1, 1, 2'd0, 4'b0001, 8'h14);
        add(0, 4'b0001, 0, 0,  1, 1, 2'd0, 4'b0001, 8'h15);
        add(0, 4'b0000, 0, 0,  1, 0, 2'd0, 4'b0001, 8'h00);
        add(0, 4'b0000, 0, 0,  0, 0, 2'd0, 4'b0000, 8'h00);
        // FIFO full for 3 cycles after the 2nd word
        add(1, 4'b0001, 0, 0,  0, 0, 2'd0, 4'b0000, 8'h00);
        add(0, 4'b0001, 0, 0,  1, 1, 2'd0, 4'b0001, 8'h10);
        add(0, 4'b0001, 0, 0,  1, 1, 2'd0, 4'b0001, 8'h11);
        add(0, 4'b0001, 1, 0,  1, 0, 2'd0, 4'b0000, 8'h00);
        add(0, 4'b0001, 1, 0,  1, 0, 2'd0, 4'b0000, 8'h00);
        add(0, 4'b0001, 1, 0,  1, 0, 2'd0, 4'b0000, 8'h00);
        add(0, 4'b0001, 0, 0,  1, 1, 2'd0, 4'b0001, 8'h12);
        add(0, 4'b0001, 0, 0,  1, 1, 2'd0, 4'b0001, 8'h13);
        add(0, 4'b0001, 0, 0,  0, 0, 2'd0, 4'b0000, 8'h00);
        // prog_full blocks grant from IDLE but not an active burst
        add(1, 4'b0010, 0, 1,  0, 0, 2'd0, 4'b0000, 8'h00);
        add(0, 4'b0010, 0, 1,  0, 0, 2'd0, 4'b0000, 8'h00);
        add(0, 4'b0010, 0, 1,  0, 0, 2'd0, 4'b0000, 8'h00);
        add(0, 4'b0010, 0, 0,  0, 0, 2'd0, 4'b0000, 8'h00);
        add(0, 4'b0010, 0, 0,  1, 1, 2'd1, 4'b0010, 8'h50);
        add(0, 4'b0010, 0, 1,  1, 1, 2'd1, 4'b0010, 8'h51);
        add(0, 4'b0010, 0, 1,  1, 1, 2'd1, 4'b0010, 8'h52);
        add(0, 4'b0010, 0, 1,  1, 1, 2'd1, 4'b0010, 8'h53);
        add(0, 4'b0010, 0, 1,  0, 0, 2'd1, 4'b0000, 8'h00);
        add(0, 4'b0010, 0, 1,  0, 0, 2'd1, 4'b0000, 8'h00);
        // Req 2 drops after 2 words while req 3 waits
        add(1, 4'b1100, 0, 0,  0, 0, 2'd0, 4'b0000, 8'h00);
        add(0, 4'b1100, 0, 0,  1, 1, 2'd2, 4'b0100, 8'h90);
        add(0, 4'b1100, 0, 0,  1, 1, 2'd2, 4'b0100, 8'h91);
        add(0, 4'b1000, 0, 0,  1, 0, 2'd2, 4'b0100, 8'h00);
        add(0, 4'b1000, 0, 0,  0, 0, 2'd2, 4'b0000, 8'h00);
        add(0, 4'b1000, 0, 0,  1, 1, 2'd3, 4'b1000, 8'hD0);

        for (int r = 0; r < vq.size(); r++) begin
            if (vq[r].rst) do_reset();
            apply(vq[r].valid, vq[r].full, vq[r].pfull);
            chk($sformatf("row%0d_busy", r),  {31'd0, busy},       {31'd0, vq[r].busy});
            chk($sformatf("row%0d_wr_en", r), {31'd0, fifo_wr_en}, {31'd0, vq[r].wr_en});
            chk($sformatf("row%0d_gid", r),   {30'd0, grant_id},   {30'd0, vq[r].gid});
            chk($sformatf("row%0d_ready", r), {28'd0, req_ready},  {28'd0, vq[r].ready});
            if (vq[r].wr_en)
                chk($sformatf("row%0d_data", r), {24'd0, fifo_wr_data}, {24'd0, vq[r].data});
            @(negedge clk);
        end

        // All requesters always valid: grants 0,1,2,3,0 of 4 words each
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) ecnt[i] = 0;
        for (int c = 0; c < 25; c++) begin
            apply(4'b1111, 0, 0);
            g = (c / 5) % NUM_REQ;
            if (c % 5 == 0) begin
                chk($sformatf("rr%0d_busy", c),  {31'd0, busy},       32'd0);
                chk($sformatf("rr%0d_wr_en", c), {31'd0, fifo_wr_en}, 32'd0);
            end else begin
                chk($sformatf("rr%0d_gid", c),   {30'd0, grant_id},   g);
                chk($sformatf("rr%0d_ready", c), {28'd0, req_ready},  32'd1 << g);
                chk($sformatf("rr%0d_wr_en", c), {31'd0, fifo_wr_en}, 32'd1);
                chk($sformatf("rr%0d_data", c),  {24'd0, fifo_wr_data},
                    {24'd0, c_base[g] + 8'(ecnt[g])});
                ecnt[g]++;
            end
            @(negedge clk);
        end

        // Asynchronous reset between edges in the middle of a burst
        do_reset();
        apply(4'b0101, 0, 0);
        @(negedge clk);
        apply(4'b0101, 0, 0);
        chk("arst_pre_busy", {31'd0, busy}, 32'd1);
        chk("arst_pre_gid",  {30'd0, grant_id}, 32'd0);
        @(negedge clk);
        #1;
        chk("arst_pre_wr_en", {31'd0, fifo_wr_en}, 32'd1);
        #1;
        rst_n = 1'b0;
        pclr  = 1'b1;
        #1;
        chk("arst_busy",  {31'd0, busy},       32'd0);
        chk("arst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        chk("arst_ready", {28'd0, req_ready},  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pclr  = 1'b0;
        apply(4'b0101, 0, 0);
        chk("arst_post_idle", {31'd0, busy}, 32'd0);
        @(negedge clk);
        apply(4'b0101, 0, 0);
        chk("arst_post_busy", {31'd0, busy},         32'd1);
        chk("arst_post_gid",  {30'd0, grant_id},     32'd0);
        chk("arst_post_data", {24'd0, fifo_wr_data}, 32'h10);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one sync_fifo write port between NUM_REQ producers in the PSK modulator datapath. Example producers: symbol mapper, preamble generator, test-pattern source.
- Producers use a valid/ready handshake.
- The arbiter grants bursts of up to MAX_BURST words and drives the FIFO wr_en/wr_data.
- It honours full (stall) and prog_full (no new burst).

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_WIDTH, 8, word width, matches the FIFO DATA_WIDTH
MAX_BURST, 4, maximum words per grant (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester word valid
req_data  in  NUM_REQ*DATA_WIDTH  packed words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready  out  NUM_REQ  per-requester accept; a word transfers when valid&&ready
fifo_wr_data  out  DATA_WIDTH  to FIFO wr_data
fifo_wr_en  out  1  to FIFO wr_en
fifo_full  in  1  from FIFO full
fifo_prog_full  in  1  from FIFO prog_full
grant_id  out  $clog2(NUM_REQ)  currently granted requester
busy  out  1  high while in BURST

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, beat_cnt=0, grant_id=0, last_grant=NUM_REQ-1, so requester 0 has first priority.
  - busy=0, req_ready=0, fifo_wr_en=0 immediately and for as long as rst_n is low.
  - fifo_wr_data is don't-care.
- Registered state: state, grant_id, last_grant, beat_cnt (width $clog2(MAX_BURST+1)).
- State IDLE:
  - busy=0, all req_ready=0, fifo_wr_en=0.
  - If any req_valid=1 and fifo_prog_full=0: select the first valid requester searching last_grant+1, last_grant+2, … modulo NUM_REQ.
  - On the next edge: grant_id=selection, last_grant=selection, beat_cnt=0, state->BURST.
  - If fifo_prog_full=1: no grant is issued; requests wait.
- State BURST:
  - busy=1.
  - req_ready[grant_id] = ~fifo_full; every other req_ready bit = 0.
  - fifo_wr_en = req_valid[grant_id] & ~fifo_full. This is combinational, zero latency from valid to wr_en.
  - fifo_wr_data = req_data slice of grant_id. It is combinational and is a valid word only when fifo_wr_en=1.
  - On each transfer, beat_cnt increments.
- BURST exit (->IDLE on the next edge):
  - (a) a transfer occurs with beat_cnt==MAX_BURST-1, i.e. MAX_BURST words have been written; or
  - (b) req_valid[grant_id]=0 in a cycle where fifo_full=0 (requester idle).
- fifo_full=1 in BURST: stall. No transfer, beat_cnt and grant held, no exit, no timeout.
- fifo_prog_full does not terminate an active burst; it only blocks new grants from IDLE.
- Arbitration costs one IDLE cycle between bursts. Maximum throughput is MAX_BURST words per MAX_BURST+1 cycles.
- Requester changes:
  - A requester whose valid drops outside its grant is simply skipped.
  - req_valid of non-granted requesters never affects the current burst.
- Invariants:
  - fifo_wr_en is never 1 while fifo_full=1.
  - fifo_wr_en=1 implies exactly one req_ready bit is high and busy=1.
  - At most one req_ready bit is high.
- Reset mid-burst: the burst is abandoned with no partial-state retention. After release, arbitration restarts from requester 0.

Test Plan:
- NUM_REQ=4, MAX_BURST=4, FIFO empty; req 0 offers 0x10..0x15 continuously:
  - -> 1 IDLE cycle, 4 writes 0x10..0x13 (grant_id=0), 1 IDLE cycle, 2 writes 0x14,0x15, then req 0 valid drops -> IDLE. FIFO contents are in order.
- All 4 requesters always valid, FIFO draining:
  - -> grant_id sequence 0,1,2,3,0, each burst exactly 4 writes separated by 1 IDLE cycle.
  - No write from a non-granted requester.
- fifo_full forced high for 3 cycles after the 2nd word of a burst:
  - -> fifo_wr_en=0 and req_ready=0 for those 3 cycles.
  - Burst resumes, totals 4 words, and grant_id is unchanged.
- fifo_prog_full=1 while IDLE with req 1 valid:
  - -> no grant, busy=0.
  - Deassert prog_full -> busy=1 on the next edge with grant_id=1.
  - prog_full rising mid-burst does not shorten the burst.
- Req 2 granted, drops valid after 2 words while req 3 is valid:
  - -> burst ends after 2 writes, IDLE, then grant_id=3.
- rst_n pulsed low mid-burst (async, between edges):
  - -> fifo_wr_en, req_ready and busy go 0 immediately.
  - After release with req 0 and req 2 valid, the first grant_id=0.
- All scenarios: a bench checker flags any fifo_wr_en while fifo_full, more than one req_ready bit high, or any data mismatch against a per-requester scoreboard.
